// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 power-up configuration sequencer.
package ov5640_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        RD_IDH,
        WT_IDH,
        RD_IDL,
        WT_IDL,
        ID_CHK,
        FETCH,
        LATCH,
        WR,
        WT_WR,
        NEXT,
        DONE,
        ERR
    } cfg_state_t;

    localparam logic [15:0] OV5640_SRST_ADDR = 16'h3008;
    localparam logic [15:0] ID_H_ADDR        = 16'h300A;
    localparam logic [15:0] ID_L_ADDR        = 16'h300B;

endpackage

// File: rtl/cfg_dly_cnt.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module cfg_dly_cnt #(
    parameter int           W    = 32,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         i_sysclk,
    input  logic         i_sysrst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n)
            cnt <= INIT;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ov5640_cfg_seq.sv
// OV5640 power-up sequencer: power-on wait, chip-ID check, then writes the external
// config table through iic_control with per-transaction NACK retry.
module ov5640_cfg_seq #(
    parameter logic [7:0]  DEV_ID    = 8'h78,
    parameter int          REG_NUM   = 252,
    parameter int          PWR_DLY   = 1_000_000,
    parameter logic [31:0] SRST_DLY  = 32'd250_000,
    parameter int          RETRY_MAX = 3,
    parameter logic [15:0] CHIP_ID   = 16'h5640
) (
    input  logic        i_sysclk,
    input  logic        i_sysrst_n,
    input  logic        i_reinit,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic        wrreg_req,
    output logic        rdreg_req,
    output logic [15:0] addr,
    output logic        addr_mode,
    output logic [7:0]  wr_data,
    output logic [7:0]  device_id,
    output logic [31:0] dly_cnt_max,
    input  logic [7:0]  rd_data,
    input  logic        rw_done,
    input  logic        ack,
    output logic        init_done,
    output logic        init_err,
    output logic [7:0]  err_idx
);
    import ov5640_pkg::*;

    localparam int          RW        = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [7:0]  LAST_IDX  = 8'(REG_NUM - 1);
    localparam logic [31:0] PWR_LOAD  = 32'(PWR_DLY - 1);

    cfg_state_t    state, nxt;
    logic [7:0]    idx;
    logic [RW-1:0] retry;
    logic [7:0]    idh, idl;
    logic          busy;
    logic          dly_done;

    // Counter is held loaded outside PWR_WAIT so every entry to PWR_WAIT starts a full wait.
    cfg_dly_cnt #(
        .W    (32),
        .INIT (PWR_LOAD)
    ) u_pwr_dly (
        .i_sysclk   (i_sysclk),
        .i_sysrst_n (i_sysrst_n),
        .load       (i_reinit || state != PWR_WAIT),
        .load_val   (PWR_LOAD),
        .en         (state == PWR_WAIT),
        .done       (dly_done)
    );

    assign rdreg_req = (state == RD_IDH) || (state == RD_IDL);
    assign wrreg_req = (state == WR);
    assign init_done = (state == DONE);
    assign init_err  = (state == ERR);
    assign rom_addr  = idx;
    assign addr_mode = 1'b1;
    assign device_id = DEV_ID;

    always_comb begin
        nxt = state;
        if (i_reinit) begin
            nxt = PWR_WAIT;
        end else begin
            case (state)
                // busy keeps a transfer abandoned by i_reinit from overlapping the next request
                PWR_WAIT: if (dly_done && !busy) nxt = RD_IDH;
                RD_IDH:   nxt = WT_IDH;
                WT_IDH:   if (rw_done) nxt = !ack ? RD_IDL : (retry == RETRY_LIM) ? ERR : RD_IDH;
                RD_IDL:   nxt = WT_IDL;
                WT_IDL:   if (rw_done) nxt = !ack ? ID_CHK : (retry == RETRY_LIM) ? ERR : RD_IDL;
                ID_CHK:   nxt = ({idh, idl} == CHIP_ID) ? FETCH : ERR;
                FETCH:    nxt = LATCH;
                LATCH:    nxt = WR;
                WR:       nxt = WT_WR;
                WT_WR:    if (rw_done) nxt = !ack ? NEXT : (retry == RETRY_LIM) ? ERR : WR;
                NEXT:     nxt = (idx == LAST_IDX) ? DONE : FETCH;
                DONE:     nxt = DONE;
                ERR:      nxt = ERR;
                default:  nxt = PWR_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state       <= PWR_WAIT;
            idx         <= '0;
            retry       <= '0;
            idh         <= '0;
            idl         <= '0;
            busy        <= 1'b0;
            addr        <= '0;
            wr_data     <= '0;
            dly_cnt_max <= '0;
            err_idx     <= '0;
        end else begin
            state <= nxt;
            if (rdreg_req || wrreg_req)
                busy <= 1'b1;
            else if (rw_done)
                busy <= 1'b0;

            if (i_reinit) begin
                idx   <= '0;
                retry <= '0;
            end else begin
                case (state)
                    WT_IDH, WT_IDL, WT_WR: begin
                        if (rw_done) begin
                            if (!ack) begin
                                retry <= '0;
                                if (state == WT_IDH) idh <= rd_data;
                                if (state == WT_IDL) idl <= rd_data;
                            end else if (retry != RETRY_LIM) begin
                                retry <= retry + 1'b1;
                            end else begin
                                err_idx <= (state == WT_WR) ? idx : 8'hFF;
                            end
                        end
                    end
                    ID_CHK: if ({idh, idl} != CHIP_ID) err_idx <= 8'hFF;
                    LATCH: begin
                        addr        <= rom_data[23:8];
                        wr_data     <= rom_data[7:0];
                        dly_cnt_max <= (rom_data[23:8] == OV5640_SRST_ADDR && rom_data[7]) ? SRST_DLY : '0;
                    end
                    NEXT: begin
                        retry <= '0;
                        if (idx != LAST_IDX) idx <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end

            // ID read address is set up on entry so it is already valid in the request cycle
            if (nxt == RD_IDH) begin
                addr        <= ID_H_ADDR;
                dly_cnt_max <= '0;
            end
            if (nxt == RD_IDL)
                addr <= ID_L_ADDR;
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: iic_control BFM, synchronous table ROM and a transaction-level model.
module tb_ov5640_cfg_seq;

    localparam int          REG_NUM   = 4;
    localparam int          PWR_DLY   = 10;
    localparam int          RETRY_MAX = 3;
    localparam int          BFM_LAT   = 20;
    localparam logic [31:0] SRST_DLY  = 32'd250_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reinit = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic        wrreg_req, rdreg_req, addr_mode, init_done, init_err;
    logic [15:0] addr;
    logic [7:0]  wr_data, device_id, err_idx;
    logic [31:0] dly_cnt_max;
    logic [7:0]  rd_data = '0;
    logic        rw_done = 1'b0;
    logic        ack = 1'b0;

    always #5 clk = ~clk;

    ov5640_cfg_seq #(.REG_NUM(REG_NUM), .PWR_DLY(PWR_DLY)) dut (
        .i_sysclk    (clk),
        .i_sysrst_n  (rst_n),
        .i_reinit    (reinit),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .wrreg_req   (wrreg_req),
        .rdreg_req   (rdreg_req),
        .addr        (addr),
        .addr_mode   (addr_mode),
        .wr_data     (wr_data),
        .device_id   (device_id),
        .dly_cnt_max (dly_cnt_max),
        .rd_data     (rd_data),
        .rw_done     (rw_done),
        .ack         (ack),
        .init_done   (init_done),
        .init_err    (init_err),
        .err_idx     (err_idx)
    );

    typedef struct packed {
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] dly;
    } txn_t;

    // one scenario: table contents, BFM behaviour, and the hand-derived final outcome
    typedef struct {
        logic [3:0][23:0] tbl;
        logic [7:0]       idh;
        logic [7:0]       idl;
        logic [3:0][2:0]  nack;
        logic [2:0]       rd_nack;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_eidx;
        int               exp_nreq;
    } vec_t;

    localparam logic [3:0][23:0] T0 = {24'h430030, 24'h3017FF, 24'h310311, 24'h300842};
    localparam logic [3:0][23:0] T5 = {24'h303669, 24'h310801, 24'h300802, 24'h300882};

    vec_t vecs[7];
    vec_t cur;
    txn_t log_q[$];
    int   log_cyc[$];
    txn_t exp_q[$];
    logic m_done, m_err;
    logic [7:0] m_eidx;

    int cyc = 0, base = 0;
    int n_vec = 0, n_bad = 0, scn = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // synchronous ROM: address seen at one edge, data visible after it
    logic [7:0] rom_a;
    initial forever begin
        @(negedge clk);
        rom_a = rom_addr;
        @(posedge clk);
        #1 rom_data = (rom_a < 8'(REG_NUM)) ? cur.tbl[rom_a[1:0]] : 24'h0;
    end

    // iic_control BFM: rw_done BFM_LAT cycles after a request
    int          pend = 0, wr_ok = 0, wr_att = 0, rd_att = 0;
    logic        pend_wr = 1'b0;
    logic [15:0] pend_addr = '0;
    initial forever begin
        @(negedge clk);
        rw_done = 1'b0;
        ack     = 1'b0;
        if (!rst_n) begin
            pend = 0; wr_ok = 0; wr_att = 0; rd_att = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rw_done = 1'b1;
                    if (pend_wr) begin
                        ack = (wr_ok < REG_NUM) && (wr_att < int'(cur.nack[wr_ok[1:0]]));
                        if (ack) wr_att++;
                        else begin wr_ok++; wr_att = 0; end
                    end else begin
                        ack     = (rd_att < int'(cur.rd_nack));
                        rd_data = (pend_addr == 16'h300A) ? cur.idh : cur.idl;
                        if (ack) rd_att++;
                        else rd_att = 0;
                    end
                end
            end
            if (rdreg_req || wrreg_req) begin
                log_q.push_back({wrreg_req, addr, wr_data, dly_cnt_max});
                log_cyc.push_back(cyc - base);
                if (pend == 0 && !rw_done) begin
                    pend      = BFM_LAT;
                    pend_wr   = wrreg_req;
                    pend_addr = addr;
                end
                if (rdreg_req) begin wr_ok = 0; wr_att = 0; end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL scn%0d %s: got %0h, want %0h", scn, nm, act, exp);
        end
    endtask

    // expected request stream from the sequencing rules, one scenario at a time
    task automatic model(input vec_t v);
        logic [15:0] a;
        exp_q.delete();
        m_done = 1'b0; m_err = 1'b0; m_eidx = 8'h00;
        for (int r = 0; r < 2; r++) begin
            a = (r == 0) ? 16'h300A : 16'h300B;
            for (int k = 0; k <= RETRY_MAX && k <= int'(v.rd_nack); k++)
                exp_q.push_back({1'b0, a, 8'h00, 32'h0});
            if (int'(v.rd_nack) > RETRY_MAX) begin m_err = 1'b1; m_eidx = 8'hFF; return; end
        end
        if ({v.idh, v.idl} != 16'h5640) begin m_err = 1'b1; m_eidx = 8'hFF; return; end
        for (int i = 0; i < REG_NUM; i++) begin
            logic [15:0] ra;
            logic [7:0]  rd;
            ra = v.tbl[i][23:8];
            rd = v.tbl[i][7:0];
            for (int k = 0; k <= RETRY_MAX && k <= int'(v.nack[i]); k++)
                exp_q.push_back({1'b1, ra, rd, (ra == 16'h3008 && rd[7]) ? SRST_DLY : 32'h0});
            if (int'(v.nack[i]) > RETRY_MAX) begin m_err = 1'b1; m_eidx = 8'(i); return; end
        end
        m_done = 1'b1;
    endtask

    task automatic cmp_txns(input int lo, input int eo, input int n);
        txn_t t, e;
        for (int k = 0; k < n; k++) begin
            if (lo + k >= log_q.size()) break;
            t = log_q[lo + k];
            e = exp_q[eo + k];
            if (e.is_wr) chk($sformatf("wr_txn%0d", lo + k), 64'(t), 64'(e));
            else chk($sformatf("rd_txn%0d", lo + k), 64'({t.is_wr, t.addr}), 64'({e.is_wr, e.addr}));
        end
    endtask

    task automatic start(input vec_t v, input bit chk_rst);
        cur = v;
        @(negedge clk);
        rst_n  = 1'b0;
        reinit = 1'b0;
        repeat (3) @(negedge clk);
        if (chk_rst) begin
            chk("rst_ctl", 64'({rdreg_req, wrreg_req, addr_mode, device_id, init_done, init_err, err_idx, rom_addr}),
                64'({1'b0, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 8'h00, 8'h00}));
            chk("rst_data", 64'({addr, wr_data, dly_cnt_max}), 64'h0);
        end
        log_q.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(init_done || init_err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("end_in_budget", 64'(n < budget), 64'd1);
        repeat (60) @(negedge clk);
    endtask

    task automatic check_end();
        model(cur);
        chk("n_req", 64'(log_q.size()), 64'(exp_q.size()));
        cmp_txns(0, 0, exp_q.size());
        chk("status", 64'({init_done, init_err, err_idx}), 64'({m_done, m_err, m_eidx}));
    endtask

    initial begin
        vec_t v;
        int   n, r;

        vecs[0] = '{T0, 8'h56, 8'h40, 12'h000, 3'd0, 1'b1, 1'b0, 8'h00, 6};
        vecs[1] = '{T0, 8'h56, 8'h41, 12'h000, 3'd0, 1'b0, 1'b1, 8'hFF, 2};
        vecs[2] = '{T0, 8'h56, 8'h40, 12'h080, 3'd0, 1'b1, 1'b0, 8'h00, 8};
        vecs[3] = '{T0, 8'h56, 8'h40, 12'h020, 3'd0, 1'b0, 1'b1, 8'h01, 7};
        vecs[4] = '{T5, 8'h56, 8'h40, 12'h000, 3'd0, 1'b1, 1'b0, 8'h00, 6};
        vecs[5] = '{T0, 8'h56, 8'h40, 12'h000, 3'd1, 1'b1, 1'b0, 8'h00, 8};
        vecs[6] = '{T0, 8'h56, 8'h40, 12'h000, 3'd4, 1'b0, 1'b1, 8'hFF, 4};

        for (int i = 0; i < 7; i++) begin
            scn = i;
            start(vecs[i], i == 0);
            wait_end(3000);
            check_end();
            chk("rec_status", 64'({init_done, init_err, err_idx, 8'(log_q.size())}),
                64'({vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_eidx, 8'(vecs[i].exp_nreq)}));
            if (i == 0) begin
                chk("first_req_cyc", 64'(log_cyc[0]), 64'd10);
                reinit = 1'b1;
                @(negedge clk);
                reinit = 1'b0;
                chk("reinit_clears", 64'({init_done, init_err, rom_addr}), 64'h0);
            end
            if (i == 4) begin
                chk("srst_dly", 64'(log_q[2].dly), 64'(SRST_DLY));
                chk("srst_b7_lo", 64'(log_q[3].dly), 64'h0);
            end
        end

        // i_reinit while entry 1 is in flight
        scn = 7;
        start(vecs[0], 1'b0);
        n = 0;
        while (log_q.size() < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_entry1", 64'(n < 2000), 64'd1);
        repeat (3) @(negedge clk);
        r = cyc - base;
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        wait_end(3000);
        model(cur);
        chk("reinit_nreq", 64'(log_q.size()), 64'(4 + exp_q.size()));
        cmp_txns(0, 0, 4);
        cmp_txns(4, 0, exp_q.size());
        chk("reinit_quiet", 64'(log_cyc[4] >= r + PWR_DLY + 1), 64'd1);
        chk("reinit_done", 64'({init_done, init_err}), 64'b10);

        // randomized scenarios
        for (int s = 0; s < 12; s++) begin
            scn = 8 + s;
            for (int k = 0; k < 4; k++) begin
                v.tbl[k]  = {($urandom_range(0, 2) == 0) ? 16'h3008 : 16'($urandom), 8'($urandom)};
                v.nack[k] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
            end
            v.rd_nack  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
            v.idh      = 8'h56;
            v.idl      = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h40;
            v.exp_done = 1'b0;
            v.exp_err  = 1'b0;
            v.exp_eidx = 8'h00;
            v.exp_nreq = 0;
            start(v, 1'b0);
            wait_end(3000);
            check_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
